// File: rtl/codec_tdm_port_pkg.sv
// Shared audio frame constants for the codec TDM port, sysmgr and codec-control blocks.
package codec_tdm_port_pkg;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned SLOT_BITS = 32;
  localparam int unsigned FRAME_LEN = 256;

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
  localparam int unsigned SLOT_W = $clog2(N_CH);
  localparam int unsigned BIT_W  = $clog2(SLOT_BITS);

  typedef logic [CNT_W-1:0]  frame_cnt_t;
  typedef logic [SLOT_W-1:0] slot_idx_t;
  typedef logic [BIT_W-1:0]  bit_idx_t;

endpackage

// File: rtl/tdm_slot_shifter.sv
// Serialize/deserialize for the currently active TDM slot; time-shared across all slots.
module tdm_slot_shifter
  import codec_tdm_port_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tx_en_i,
  input  logic         rx_en_i,
  input  bit_idx_t     bit_idx_i,
  input  logic [W-1:0] tx_word_i,
  input  logic         sdin_i,
  input  logic [W-1:0] cap_i,
  output logic         sdout_o,
  output logic [W-1:0] cap_o,
  output logic         cap_we_o
);

  logic         in_sample;
  logic [W-1:0] tx_shifted;
  logic         sdout_q;

  always_comb begin
    in_sample  = 32'(bit_idx_i) < W;
    // MSB-first: the bit to send sits at the top after shifting left by the bit index.
    tx_shifted = tx_word_i << bit_idx_i;
    cap_o      = {cap_i[W-2:0], sdin_i};
    cap_we_o   = rx_en_i && in_sample;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sdout_q <= 1'b0;
    end else if (tx_en_i) begin
      sdout_q <= in_sample & tx_shifted[W-1];
    end
  end

  assign sdout_o = sdout_q;

endmodule

// File: rtl/codec_tdm_port.sv
// Four-channel TDM audio codec port: BICK/LRCK generation, DAC serializer, ADC capture.
module codec_tdm_port
  import codec_tdm_port_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_256fs,
  input  logic         rst,
  input  logic [W-1:0] dac0,
  input  logic [W-1:0] dac1,
  input  logic [W-1:0] dac2,
  input  logic [W-1:0] dac3,
  output logic [W-1:0] adc0,
  output logic [W-1:0] adc1,
  output logic [W-1:0] adc2,
  output logic [W-1:0] adc3,
  output logic         sample_valid,
  output logic         bick,
  output logic         lrck,
  output logic         sdout,
  input  logic         sdin
);

  frame_cnt_t   cnt_q;
  logic         bick_q, lrck_q, sample_valid_q;
  logic [W-1:0] hold_q [N_CH];
  logic [W-1:0] cap_q  [N_CH];
  logic [W-1:0] adc_q  [N_CH];
  logic [W-1:0] dac_arr[N_CH];

  slot_idx_t    slot;
  bit_idx_t     bit_idx;
  logic         frame_end;
  logic [W-1:0] cur_tx, cur_cap, cap_next;
  logic         cap_we;

  always_comb begin
    slot       = cnt_q[CNT_W-1 -: SLOT_W];
    bit_idx    = cnt_q[BIT_W:1];
    frame_end  = (cnt_q == frame_cnt_t'(FRAME_LEN - 1));
    dac_arr[0] = dac0;
    dac_arr[1] = dac1;
    dac_arr[2] = dac2;
    dac_arr[3] = dac3;
    cur_tx     = hold_q[slot];
    cur_cap    = cap_q[slot];
  end

  tdm_slot_shifter #(
    .W (W)
  ) u_shifter (
    .clk_i     (clk_256fs),
    .rst_i     (rst),
    .tx_en_i   (~cnt_q[0]),
    .rx_en_i   (cnt_q[0]),
    .bit_idx_i (bit_idx),
    .tx_word_i (cur_tx),
    .sdin_i    (sdin),
    .cap_i     (cur_cap),
    .sdout_o   (sdout),
    .cap_o     (cap_next),
    .cap_we_o  (cap_we)
  );

  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      bick_q         <= 1'b0;
      lrck_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
        cap_q[i]  <= '0;
        adc_q[i]  <= '0;
      end
    end else begin
      cnt_q          <= cnt_q + frame_cnt_t'(1);
      bick_q         <= cnt_q[0];
      lrck_q         <= ~cnt_q[CNT_W-1];
      sample_valid_q <= frame_end;
      if (cap_we) begin
        cap_q[slot] <= cap_next;
      end
      if (frame_end) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          hold_q[i] <= dac_arr[i];
          // Forward a capture landing on this same edge so wide samples keep their last bit.
          adc_q[i]  <= (cap_we && slot == SLOT_W'(i)) ? cap_next : cap_q[i];
        end
      end
    end
  end

  assign bick         = bick_q;
  assign lrck         = lrck_q;
  assign sample_valid = sample_valid_q;
  assign adc0         = adc_q[0];
  assign adc1         = adc_q[1];
  assign adc2         = adc_q[2];
  assign adc3         = adc_q[3];

endmodule
